weight_csr_encoder: RTL
=======================

// Module: weight_csr_encoder
// PURPOSE
//  Upstream loader for the compressed weight store of accelerator_top. Takes a row-major stream of dense
//  weight words and emits the wr_compressed/wr_comp_* write stream (row, col idx, packed ptr, value), using
//  IDX_SENTINEL for zero columns. Also builds the global active-column mask/count for sparse scheduling.
// PARAMETERS
//  WORD_SIZE     64     bits per weight word
//  NUM_PES       64     rows per load (one per PE)
//  SRAM_DEPTH    64     columns per row
//  IDX_SENTINEL  6'h3F  ptr code meaning zero column; also max usable ptr + 1
// PORTS
//  clk              in   1          clock
//  reset_n          in   1          synchronous, active-low reset
//  start            in   1          pulse: begin a load of NUM_PES x SRAM_DEPTH words
//  busy             out  1          high from cycle after accepted start until done
//  done             out  1          1-cycle pulse after last word emitted; stats valid
//  in_valid         in   1          dense word valid
//  in_ready         out  1          high while state==STREAM
//  in_data          in   WORD_SIZE  dense weight word, row-major order
//  wr_compressed    out  1          write strobe to accelerator_top
//  wr_comp_row      out  6          PE row
//  wr_comp_idx      out  6          column index
//  wr_comp_ptr      out  6          packed-value index, or IDX_SENTINEL
//  wr_comp_val      out  WORD_SIZE  word value (0 when ptr==IDX_SENTINEL)
//  active_col_mask  out  SRAM_DEPTH bit c = 1 if any row has nonzero in column c
//  active_col_count out  7          popcount(active_col_mask), 0..64
//  total_nz         out  13         nonzero words stored across all rows, 0..4096
//  overflow_err     out  1          sticky: a row exceeded IDX_SENTINEL nonzeros
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; row/col/ptr counters, mask, stats, overflow_err cleared.
//  - FSM IDLE -> STREAM on start (start ignored in STREAM/DONE); entering STREAM clears mask, stats, err.
//  - STREAM: word accepted when in_valid & in_ready; counters col (0..63), row (0..NUM_PES-1), nz_ptr.
//  - Per accepted word, registered outputs next cycle (latency 1): wr_compressed=1, row, idx=col;
//    if in_data!=0 and nz_ptr<IDX_SENTINEL: ptr=nz_ptr, val=in_data, nz_ptr++, mask[col]=1, total_nz++;
//    if in_data==0: ptr=IDX_SENTINEL, val=0;
//    if in_data!=0 and nz_ptr==IDX_SENTINEL (64th nonzero in row): ptr=IDX_SENTINEL, val=0, overflow_err=1.
//  - No accepted word -> wr_compressed=0 that cycle (other wr_comp_* hold). No downstream backpressure.
//  - col wraps 63->0 with row++ and nz_ptr reset to 0. Accept of row NUM_PES-1, col 63 -> DONE.
//  - DONE (1 cycle): last word already on outputs; active_col_count registered from final mask; done=1,
//    busy=0 next; -> IDLE. Mask/count/total_nz/overflow_err hold until next start or reset.
//  - reset_n low mid-load: immediate abort to IDLE, all cleared; no done pulse.
//  - busy=1 in STREAM and DONE; in_ready=0 in IDLE/DONE.
// STRUCTURE
//  - Package bnn_comp_pkg: IDX_SENTINEL, IDX_W=6, WORD_SIZE, state enum {IDLE,STREAM,DONE},
//    comp_wr_t struct {row,idx,ptr,val}.
//  - One sub-module: col_popcount (SRAM_DEPTH-bit mask -> 7-bit count, combinational, registered here).
// TESTING
//  - 75% sparse: all-ones words at col%4==0, zero elsewhere, 64 rows -> per row ptr 0..15 on cols 0,4..60,
//    ptr 3F elsewhere; active_col_count=16, total_nz=1024, overflow_err=0.
//  - 90% sparse: nonzero only at col%10==0 && col<60 -> ptr 0..5 on cols 0..50; active_col_count=6,
//    total_nz=384.
//  - Dense row 0 (64 nonzeros): cols 0..62 ptr 0..62; col 63 ptr 3F val 0; overflow_err=1, total_nz=63.
//  - Random in_valid gaps: wr_compressed only 1 cycle after each accept; 4096 strobes; done exactly once.
//  - start pulsed during STREAM -> ignored, counters unchanged; all-zero load -> mask=0, count=0, done.
//  - reset_n low at row 10 col 5 -> next cycle busy=0, outputs 0, no done; fresh start loads correctly.

Source files
------------

// File: rtl/bnn_comp_pkg.sv
// ============================================================================
// Module      : bnn_comp_pkg
// Description : Shared constants and types for the compressed-weight encoder.
//               Contains the field widths, the sentinel pointer code, the FSM
//               state encoding and the compressed write record.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bnn_comp_pkg;

    localparam int WORD_SIZE  = 64;   // bits per weight word
    localparam int NUM_PES    = 64;   // rows per load, one per PE
    localparam int SRAM_DEPTH = 64;   // columns per row
    localparam int IDX_W      = 6;    // width of row / col / ptr fields
    localparam int CNT_W      = 7;    // width of active column count (0..64)
    localparam int NZ_W       = 13;   // width of total nonzero count (0..4096)

    // Pointer code for a zero (or dropped) column; also one past the
    // largest usable packed-value index.
    localparam logic [IDX_W-1:0] IDX_SENTINEL = 6'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]     row;
        logic [IDX_W-1:0]     idx;
        logic [IDX_W-1:0]     ptr;
        logic [WORD_SIZE-1:0] val;
    } comp_wr_t;

endpackage

`default_nettype wire

// File: rtl/weight_csr_encoder_col_popcount.sv
// ============================================================================
// Module      : col_popcount
// Description : Combinational population count of the active-column mask.
//               The caller registers the result.
// Ports       : mask_i  [WIDTH-1:0]  column mask
//               count_o [CNT_W-1:0]  number of set bits in mask_i
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module col_popcount #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(mask_i[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/weight_csr_encoder.sv
// ============================================================================
// Module      : weight_csr_encoder
// Description : Converts a row-major stream of dense weight words into the
//               compressed write stream of the weight store (row, column
//               index, packed pointer, value). Zero columns get the sentinel
//               pointer. Also collects the global active-column mask, its
//               popcount, the total stored nonzeros and a sticky overflow
//               flag for rows holding more nonzeros than pointer codes.
// Ports       : clk              clock
//               reset_n          synchronous active-low reset
//               start_i          begin a NUM_PES x SRAM_DEPTH load
//               busy_o           load in progress (STREAM or DONE)
//               done_o           1-cycle pulse, statistics valid
//               in_valid_i       dense word valid
//               in_ready_o       encoder accepting words (STREAM)
//               in_data_i        dense weight word
//               wr_compressed_o  compressed write strobe
//               wr_comp_row_o    PE row
//               wr_comp_idx_o    column index
//               wr_comp_ptr_o    packed-value index or sentinel
//               wr_comp_val_o    stored value (0 for sentinel)
//               active_col_mask_o  columns nonzero in any row
//               active_col_count_o popcount of the mask
//               total_nz_o       nonzero words stored
//               overflow_err_o   sticky row overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module weight_csr_encoder
    import bnn_comp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_SIZE-1:0]  in_data_i,
    output logic                  wr_compressed_o,
    output logic [IDX_W-1:0]      wr_comp_row_o,
    output logic [IDX_W-1:0]      wr_comp_idx_o,
    output logic [IDX_W-1:0]      wr_comp_ptr_o,
    output logic [WORD_SIZE-1:0]  wr_comp_val_o,
    output logic [SRAM_DEPTH-1:0] active_col_mask_o,
    output logic [CNT_W-1:0]      active_col_count_o,
    output logic [NZ_W-1:0]       total_nz_o,
    output logic                  overflow_err_o
);

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(SRAM_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PES - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        row_q;
    logic [IDX_W-1:0]        col_q;
    logic [IDX_W-1:0]        nz_ptr_q;
    comp_wr_t                wr_q;
    logic                    wr_en_q;
    logic                    done_q;
    logic [SRAM_DEPTH-1:0]   mask_q;
    logic [CNT_W-1:0]        count_q;
    logic [NZ_W-1:0]         total_q;
    logic                    err_q;

    logic                    w_accept;
    logic                    w_last_word;
    logic                    w_load_start;
    logic [CNT_W-1:0]        w_popcount;

    assign w_accept     = in_valid_i && (state_q == STREAM);
    assign w_last_word  = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign w_load_start = (state_q == IDLE) && start_i;

    col_popcount #(
        .WIDTH (SRAM_DEPTH),
        .CNT_W (CNT_W)
    ) u_col_popcount (
        .mask_i  (mask_q),
        .count_o (w_popcount)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = STREAM;
            STREAM:  if (w_accept && w_last_word) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            nz_ptr_q <= '0;
            wr_q     <= '0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            count_q  <= '0;
            total_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= w_accept;
            // done follows the single DONE cycle, so the count loaded
            // there is already visible when done rises.
            done_q  <= (state_q == DONE);

            if (w_load_start) begin
                row_q    <= '0;
                col_q    <= '0;
                nz_ptr_q <= '0;
                mask_q   <= '0;
                count_q  <= '0;
                total_q  <= '0;
                err_q    <= 1'b0;
            end

            if (w_accept) begin
                wr_q.row <= row_q;
                wr_q.idx <= col_q;
                if (in_data_i == '0) begin
                    wr_q.ptr <= IDX_SENTINEL;
                    wr_q.val <= '0;
                end else if (nz_ptr_q != IDX_SENTINEL) begin
                    wr_q.ptr         <= nz_ptr_q;
                    wr_q.val         <= in_data_i;
                    nz_ptr_q         <= nz_ptr_q + 1'b1;
                    mask_q[col_q]    <= 1'b1;
                    total_q          <= total_q + 1'b1;
                end else begin
                    // No pointer code left in this row: drop the value.
                    wr_q.ptr <= IDX_SENTINEL;
                    wr_q.val <= '0;
                    err_q    <= 1'b1;
                end

                // Row wrap overrides the nz_ptr increment above.
                if (col_q == LAST_COL) begin
                    col_q    <= '0;
                    row_q    <= row_q + 1'b1;
                    nz_ptr_q <= '0;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (state_q == DONE) begin
                count_q <= w_popcount;
            end
        end
    end

    assign busy_o             = (state_q != IDLE);
    assign in_ready_o         = (state_q == STREAM);
    assign done_o             = done_q;
    assign wr_compressed_o    = wr_en_q;
    assign wr_comp_row_o      = wr_q.row;
    assign wr_comp_idx_o      = wr_q.idx;
    assign wr_comp_ptr_o      = wr_q.ptr;
    assign wr_comp_val_o      = wr_q.val;
    assign active_col_mask_o  = mask_q;
    assign active_col_count_o = count_q;
    assign total_nz_o         = total_q;
    assign overflow_err_o     = err_q;

endmodule

`default_nettype wire
